// File: rtl/branch_flag_gen_pkg.sv
// Shared branch defines: funct3 codes, FSM encoding, default chunk width
// and the flag bundle used by the serial compare unit.
package branch_flag_gen_pkg;

    // Branch funct3 codes consumed by the branch control unit
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Bits of the subtraction handled per clock by default
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic z;
        logic s;
        logic v;
        logic c;
    } flags_t;

    // Number of cycles a compare spends in BUSY
    function automatic int chunk_count(input int n, input int chunk);
        return n / chunk;
    endfunction

endpackage

// File: rtl/branch_flag_gen_if.sv
// Request/response bundle between the branch requester and the flag generator.
// The master issues rs1/rs2 and consumes flags; the slave is the flag generator.
interface branch_flag_gen_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic         out_valid;
    logic         out_ready;
    logic         ZFlag;
    logic         SFlag;
    logic         VFlag;
    logic         CFlag;

    modport master (
        output in_valid, rs1, rs2, out_ready,
        input  in_ready, out_valid, ZFlag, SFlag, VFlag, CFlag
    );

    modport slave (
        input  in_valid, rs1, rs2, out_ready,
        output in_ready, out_valid, ZFlag, SFlag, VFlag, CFlag
    );
endinterface

// File: rtl/branch_flag_gen_slice.sv
// One chunk of the serial subtractor: a + b_inv + cin, where the caller
// supplies the already inverted second operand. Also reports whether the
// chunk sum is zero and the carry into its MSB (for signed overflow).
module flag_gen_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b_inv,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero,
    output logic         msb_cin
);
    logic [W:0] total;

    // Plain ripple add of the chunk plus carry-in; MSB carry-in recovered from the sum bit
    always_comb begin
        total   = {1'b0, a} + {1'b0, b_inv} + {{W{1'b0}}, cin};
        sum     = total[W-1:0];
        cout    = total[W];
        zero    = ~|total[W-1:0];
        msb_cin = a[W-1] ^ b_inv[W-1] ^ total[W-1];
    end
endmodule

// File: rtl/branch_flag_gen.sv
// Serial branch flag generator: evaluates rs1 - rs2 one chunk per cycle,
// LSB chunk first, and presents Z/S/V/C flags for the branch control unit.
// N must be a multiple of CHUNK.
module branch_flag_gen
    import branch_flag_gen_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input logic              clk,
    input logic              rst_n,
    branch_flag_gen_if.slave bus
);
    localparam int NCH   = chunk_count(N, CHUNK);
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             z_acc;
    logic [N-1:0]     a_sh;
    logic [N-1:0]     b_sh;
    logic             out_valid_q;
    flags_t           flags_q;

    logic [CHUNK-1:0] b_inv;
    logic [CHUNK-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_zero;
    logic             sl_msb_cin;
    logic [N-1:0]     sum_ext;
    logic             accept;

    assign b_inv   = ~b_sh[CHUNK-1:0];
    assign sum_ext = N'(sl_sum);
    assign accept  = bus.in_valid && bus.in_ready;

    flag_gen_slice #(.W(CHUNK)) u_slice (
        .a       (a_sh[CHUNK-1:0]),
        .b_inv   (b_inv),
        .cin     (carry),
        .sum     (sl_sum),
        .cout    (sl_cout),
        .zero    (sl_zero),
        .msb_cin (sl_msb_cin)
    );

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.ZFlag     = flags_q.z;
    assign bus.SFlag     = flags_q.s;
    assign bus.VFlag     = flags_q.v;
    assign bus.CFlag     = flags_q.c;

    // Compare FSM: latch operands, shift chunks through the slice, hold flags until taken.
    // Result chunks are shifted into the top of a_sh as operand chunks leave the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            z_acc       <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= bus.rs1;
                        b_sh  <= bus.rs2;
                        carry <= 1'b1;
                        z_acc <= 1'b1;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh  <= (a_sh >> CHUNK) | (sum_ext << (N - CHUNK));
                    b_sh  <= b_sh >> CHUNK;
                    carry <= sl_cout;
                    z_acc <= z_acc & sl_zero;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NCH - 1)) begin
                        flags_q.z   <= z_acc & sl_zero;
                        flags_q.s   <= sl_sum[CHUNK-1];
                        flags_q.v   <= sl_msb_cin ^ sl_cout;
                        flags_q.c   <= sl_cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_sh  <= bus.rs1;
                            b_sh  <= bus.rs2;
                            carry <= 1'b1;
                            z_acc <= 1'b1;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
